vga_sync: RTL and testbench

VGA_SYNC -- requirements
Module: vga_sync

---
 rtl/vga_sync.sv | 95 +++++++++
 tb/tb_vga_sync.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/vga_sync.sv
// VGA timing generator: free-running pixel/line counters, sync pulses and a
// three-layer colour mux, with sync and colour sharing one output register stage.
module vga_sync #(
    parameter int H_VIS  = 640,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_VIS  = 480,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33
) (
    input  logic       clk25M,
    input  logic       reset,
    input  logic       ball_on,
    input  logic [7:0] ball_rgb,
    input  logic       paddle_on,
    input  logic [7:0] paddle_rgb,
    input  logic [7:0] bg_rgb,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic       vga_on,
    output logic       endofframe,
    output logic       hsync,
    output logic       vsync,
    output logic [2:0] red,
    output logic [2:0] green,
    output logic [1:0] blue
);

    localparam logic [9:0] H_LAST   = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] V_LAST   = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);
    localparam logic [9:0] EOF_LINE = 10'(V_VIS + 1);

    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_wrap;
    logic       hsync_raw;
    logic       vsync_raw;
    logic [7:0] pix_rgb;

    assign h_wrap = (h_cnt == H_LAST);

    always_ff @(posedge clk25M) begin
        if (reset) begin
            h_cnt <= 10'd0;
            v_cnt <= 10'd0;
        end else if (h_wrap) begin
            h_cnt <= 10'd0;
            v_cnt <= (v_cnt == V_LAST) ? 10'd0 : v_cnt + 10'd1;
        end else begin
            h_cnt <= h_cnt + 10'd1;
        end
    end

    // Position and frame tick come straight off the counters for the layer logic.
    assign x          = h_cnt;
    assign y          = v_cnt;
    assign vga_on     = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign endofframe = (h_cnt == 10'd0) && (v_cnt == EOF_LINE);

    always_comb begin
        hsync_raw = !((h_cnt >= HS_START) && (h_cnt < HS_END));
        vsync_raw = !((v_cnt >= VS_START) && (v_cnt < VS_END));
        pix_rgb   = 8'h00;
        if (vga_on) begin
            if (ball_on)
                pix_rgb = ball_rgb;
            else if (paddle_on)
                pix_rgb = paddle_rgb;
            else
                pix_rgb = bg_rgb;
        end
    end

    // Single register stage keeps the syncs aligned with the colour they frame.
    always_ff @(posedge clk25M) begin
        if (reset) begin
            hsync              <= 1'b1;
            vsync              <= 1'b1;
            {red, green, blue} <= 8'h00;
        end else begin
            hsync              <= hsync_raw;
            vsync              <= vsync_raw;
            {red, green, blue} <= pix_rgb;
        end
    end

endmodule

// File: tb/tb_vga_sync.sv
// Scoreboard bench for vga_sync: a shrunken-timing instance covers whole frames,
// a default-timing instance covers the first lines at full size.
module tb_vga_sync;

    logic clk25M = 1'b0;
    logic reset  = 1'b1;
    always #20 clk25M = ~clk25M;

    int   cyc      = 0;
    logic rst_seen = 1'b1;
    always @(posedge clk25M) begin
        cyc      <= cyc + 1;
        rst_seen <= reset;
    end

    // Small instance: 55 clocks per line, 37 lines per frame.
    logic [9:0] sx, sy;
    logic       s_von, s_eof, s_hs, s_vs;
    logic [2:0] s_r, s_g;
    logic [1:0] s_b;
    logic       s_ball_on, s_pad_on;
    logic [7:0] s_ball_rgb;

    always_comb begin
        s_ball_on  = (sy == 10'd10) && ((sx == 10'd10) || (sx == 10'd45));
        s_ball_rgb = (sx == 10'd45) ? 8'hFF : 8'hE0;
        s_pad_on   = (sy == 10'd10) && (sx >= 10'd10) && (sx <= 10'd12);
    end

    vga_sync #(
        .H_VIS(40), .H_FP(4), .H_SYNC(6), .H_BP(5),
        .V_VIS(30), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dut_small (
        .clk25M(clk25M), .reset(reset),
        .ball_on(s_ball_on), .ball_rgb(s_ball_rgb),
        .paddle_on(s_pad_on), .paddle_rgb(8'h1C), .bg_rgb(8'h03),
        .x(sx), .y(sy), .vga_on(s_von), .endofframe(s_eof),
        .hsync(s_hs), .vsync(s_vs), .red(s_r), .green(s_g), .blue(s_b)
    );

    logic [9:0] dx, dy;
    logic       d_von, d_eof, d_hs, d_vs;
    logic [2:0] d_r, d_g;
    logic [1:0] d_b;
    logic       d_ball_on, d_pad_on;
    logic [7:0] d_ball_rgb;

    always_comb begin
        d_ball_on  = (dy == 10'd0) && ((dx == 10'd100) || (dx == 10'd700));
        d_ball_rgb = (dx == 10'd700) ? 8'hFF : 8'hE0;
        d_pad_on   = (dy == 10'd0) && (dx >= 10'd100) && (dx <= 10'd101);
    end

    vga_sync dut_dflt (
        .clk25M(clk25M), .reset(reset),
        .ball_on(d_ball_on), .ball_rgb(d_ball_rgb),
        .paddle_on(d_pad_on), .paddle_rgb(8'h1C), .bg_rgb(8'h25),
        .x(dx), .y(dy), .vga_on(d_von), .endofframe(d_eof),
        .hsync(d_hs), .vsync(d_vs), .red(d_r), .green(d_g), .blue(d_b)
    );

    typedef struct {
        int          cyc;
        int          id;
        bit          big;
        logic [31:0] exp;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   passes    = 0;
    int   base      = 0;
    int   eof_count = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got === exp)
            passes++;
        else
            $display("[TB] FAIL %s: got %h expected %h at cycle %0d", name, got, exp, cyc);
    endtask

    // Expected packing: {x, y, vga_on, endofframe, hsync, vsync, rgb}
    task automatic push(input bit big, input int k, input int id,
                        input logic [9:0] ex, input logic [9:0] ey,
                        input logic ev, input logic ee, input logic eh,
                        input logic evs, input logic [7:0] ergb);
        exp_t e;
        e.cyc = base + k;
        e.id  = id;
        e.big = big;
        e.exp = {ex, ey, ev, ee, eh, evs, ergb};
        sb.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk25M);
    endtask

    // Monitor: serves scoreboard entries due this cycle plus pulse-shape checks.
    initial begin
        int          s_hlow    = 0;
        int          s_vlow    = 0;
        int          d_hlow    = 0;
        logic        s_hs_prev = 1'b1;
        logic        s_vs_prev = 1'b1;
        logic        d_hs_prev = 1'b1;
        logic [31:0] got;
        forever begin
            @(negedge clk25M);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    got = sb[i].big ? {dx, dy, d_von, d_eof, d_hs, d_vs, d_r, d_g, d_b}
                                    : {sx, sy, s_von, s_eof, s_hs, s_vs, s_r, s_g, s_b};
                    check($sformatf("%s_vec%0d", sb[i].big ? "dflt" : "small", sb[i].id),
                          got, sb[i].exp);
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    checks++;
                    $display("[TB] FAIL missed_vec%0d: got none expected %h", sb[i].id, sb[i].exp);
                    sb.delete(i);
                end
            end
            if (rst_seen) begin
                s_hlow = 0; s_vlow = 0; d_hlow = 0;
                s_hs_prev = 1'b1; s_vs_prev = 1'b1; d_hs_prev = 1'b1;
            end else begin
                if (!s_hs) begin
                    if (s_hs_prev) check("small_hs_fall_x", 32'(sx), 32'd45);
                    s_hlow++;
                end else if (!s_hs_prev) begin
                    check("small_hs_width", 32'(s_hlow), 32'd6);
                    s_hlow = 0;
                end
                s_hs_prev = s_hs;
                if (!s_vs) begin
                    if (s_vs_prev) check("small_vs_fall_xy", 32'({sx, sy}), 32'({10'd1, 10'd32}));
                    s_vlow++;
                end else if (!s_vs_prev) begin
                    check("small_vs_width", 32'(s_vlow), 32'd110);
                    s_vlow = 0;
                end
                s_vs_prev = s_vs;
                if (!d_hs) begin
                    if (d_hs_prev) check("dflt_hs_fall_x", 32'(dx), 32'd657);
                    d_hlow++;
                end else if (!d_hs_prev) begin
                    check("dflt_hs_width", 32'(d_hlow), 32'd96);
                    d_hlow = 0;
                end
                d_hs_prev = d_hs;
                if (s_eof) begin
                    eof_count++;
                    check("small_eof_xy", 32'({sx, sy}), 32'({10'd0, 10'd31}));
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c1;
        reset = 1'b1;
        repeat (3) @(negedge clk25M);
        base = cyc + 1;
        push(0, 0,     0, 10'd0,  10'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 1,     1, 10'd1,  10'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'h03);
        push(0, 40,    2, 10'd40, 10'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'h03);
        push(0, 41,    3, 10'd41, 10'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 45,    4, 10'd45, 10'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        push(0, 50,    5, 10'd50, 10'd0,  1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        push(0, 51,    6, 10'd51, 10'd0,  1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 55,    7, 10'd0,  10'd1,  1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 561,   8, 10'd11, 10'd10, 1'b1, 1'b0, 1'b1, 1'b1, 8'hE0);
        push(0, 562,   9, 10'd12, 10'd10, 1'b1, 1'b0, 1'b1, 1'b1, 8'h1C);
        push(0, 564,  10, 10'd14, 10'd10, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03);
        push(0, 596,  11, 10'd46, 10'd10, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        push(0, 1601, 12, 10'd6,  10'd29, 1'b1, 1'b0, 1'b1, 1'b1, 8'h03);
        push(0, 1655, 13, 10'd5,  10'd30, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 1705, 14, 10'd0,  10'd31, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        push(0, 1706, 15, 10'd1,  10'd31, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 1760, 16, 10'd0,  10'd32, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 1761, 17, 10'd1,  10'd32, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        push(0, 1870, 18, 10'd0,  10'd34, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00);
        push(0, 1871, 19, 10'd1,  10'd34, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 2035, 20, 10'd0,  10'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 2036, 21, 10'd1,  10'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'h03);
        push(0, 3841, 22, 10'd46, 10'd32, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        push(0, 3842, 23, 10'd0,  10'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        push(0, 3843, 24, 10'd0,  10'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        push(1, 0,    30, 10'd0,   10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        push(1, 101,  31, 10'd101, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'hE0);
        push(1, 102,  32, 10'd102, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h1C);
        push(1, 103,  33, 10'd103, 10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h25);
        push(1, 640,  34, 10'd640, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h25);
        push(1, 656,  35, 10'd656, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(1, 657,  36, 10'd657, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        push(1, 701,  37, 10'd701, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        push(1, 752,  38, 10'd752, 10'd0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
        push(1, 753,  39, 10'd753, 10'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h00);
        push(1, 800,  40, 10'd0,   10'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        push(1, 801,  41, 10'd1,   10'd1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h25);
        push(1, 3842, 42, 10'd0,   10'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h00);
        @(negedge clk25M);
        reset = 1'b0;

        // Reset mid-frame while both sync pins of the small instance are low.
        wait_cyc(base + 3841);
        reset = 1'b1;
        wait_cyc(base + 3843);
        reset = 1'b0;
        c1   = cyc;
        base = c1;
        push(0, 1,    50, 10'd1, 10'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'h03);
        push(0, 1705, 51, 10'd0, 10'd31, 1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        push(0, 2036, 52, 10'd1, 10'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'h03);
        push(1, 1,    53, 10'd1, 10'd0,  1'b1, 1'b0, 1'b1, 1'b1, 8'h25);

        wait_cyc(c1 + 2045);
        @(negedge clk25M);
        foreach (sb[i]) begin
            checks++;
            $display("[TB] FAIL unserved_vec%0d: got none expected %h", sb[i].id, sb[i].exp);
        end
        check("small_eof_count", 32'(eof_count), 32'd3);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
